// File: rtl/dct_8x8_sequencer.sv
// rtl/dct_8x8_sequencer.sv - runs a 1-D DCT engine 16 times (8 rows, 8 columns) for one 8x8 block
// Optional watchdog on the RUN state enabled by defining DCT_SEQ_WATCHDOG_EN.
module dct_8x8_sequencer #(
   parameter int RESET_CYCLES   = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clock,
   input  logic       nreset,
   input  logic       start,
   output logic       busy,
   output logic       block_done,
   output logic       pass,
   output logic [2:0] line,
   output logic       dct_nreset,
   input  logic       dct_done,
   input  logic [2:0] dct_fetch_addr,
   input  logic [2:0] dct_result_addr,
   input  logic       dct_result_wren,
   output logic [5:0] src_raddr,
   output logic [5:0] dst_waddr,
   output logic       dst_wren,
   output logic       error
);

   localparam logic [1:0] LP_IDLE = 2'd0;
   localparam logic [1:0] LP_HOLD = 2'd1;
   localparam logic [1:0] LP_RUN  = 2'd2;
   localparam logic [1:0] LP_NEXT = 2'd3;

   localparam logic [7:0] LP_HOLD_LAST = 8'(RESET_CYCLES - 1);

   logic [1:0] r_state;
   logic       r_pass;
   logic [2:0] r_line;
   logic [7:0] r_hold_cnt;
   logic       r_run_first;
   logic       r_block_done;
   logic       w_in_run;

`ifdef DCT_SEQ_WATCHDOG_EN
   localparam int LP_WDOG_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [LP_WDOG_W-1:0] LP_TO_LAST = LP_WDOG_W'(TIMEOUT_CYCLES - 1);

   logic [LP_WDOG_W-1:0] r_wdog;
   logic                 r_error;
`endif

   assign w_in_run = (r_state == LP_RUN);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_state      <= LP_IDLE;
         r_pass       <= 1'b0;
         r_line       <= 3'd0;
         r_hold_cnt   <= 8'd0;
         r_run_first  <= 1'b0;
         r_block_done <= 1'b0;
`ifdef DCT_SEQ_WATCHDOG_EN
         r_wdog       <= '0;
         r_error      <= 1'b0;
`endif
      end else begin
         r_block_done <= 1'b0;
         case (r_state)
            LP_IDLE: begin
               if (start) begin
                  r_pass     <= 1'b0;
                  r_line     <= 3'd0;
                  r_hold_cnt <= 8'd0;
                  r_state    <= LP_HOLD;
`ifdef DCT_SEQ_WATCHDOG_EN
                  r_error    <= 1'b0;
`endif
               end
            end
            LP_HOLD: begin
               if (r_hold_cnt == LP_HOLD_LAST) begin
                  r_hold_cnt  <= 8'd0;
                  r_run_first <= 1'b1;
                  r_state     <= LP_RUN;
`ifdef DCT_SEQ_WATCHDOG_EN
                  r_wdog      <= '0;
`endif
               end else begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end
            LP_RUN: begin
               r_run_first <= 1'b0;
               // The engine may still present a stale done on its first released cycle.
               if (!r_run_first && dct_done) begin
                  r_state <= LP_NEXT;
`ifdef DCT_SEQ_WATCHDOG_EN
               end else if (r_wdog == LP_TO_LAST) begin
                  r_error <= 1'b1;
                  r_pass  <= 1'b0;
                  r_line  <= 3'd0;
                  r_state <= LP_IDLE;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
`endif
               end
            end
            LP_NEXT: begin
               if (r_line != 3'd7) begin
                  r_line  <= r_line + 3'd1;
                  r_state <= LP_HOLD;
               end else if (!r_pass) begin
                  r_pass  <= 1'b1;
                  r_line  <= 3'd0;
                  r_state <= LP_HOLD;
               end else begin
                  r_block_done <= 1'b1;
                  r_pass       <= 1'b0;
                  r_line       <= 3'd0;
                  r_state      <= LP_IDLE;
               end
            end
            default: r_state <= LP_IDLE;
         endcase
      end
   end

   assign busy       = (r_state != LP_IDLE);
   assign block_done = r_block_done;
   assign pass       = r_pass;
   assign line       = r_line;
   assign dct_nreset = w_in_run;

   // Transposed store: results of line L land in column L, so pass 1 output is row-major.
   assign src_raddr = {r_line, dct_fetch_addr};
   assign dst_waddr = {dct_result_addr, r_line};
   assign dst_wren  = dct_result_wren & w_in_run;

`ifdef DCT_SEQ_WATCHDOG_EN
   assign error = r_error;
`else
   // Only a nonsensical timeout setting could make this nonzero.
   assign error = (TIMEOUT_CYCLES < 1);
`endif

endmodule

// File: doc/dct_8x8_sequencer.md
Name: dct_8x8_sequencer

Overview:
Controller that runs the 1-D 8-point DCT engine (loeffler_dct_8) sixteen times to produce one 8x8 2-D DCT. Pass 0 runs 8 row transforms; pass 1 runs 8 column transforms. Each run is started by pulsing the engine's reset. The block remaps the engine's 3-bit fetch and result addresses to 6-bit block-memory addresses with a transposed store, so the final output lands in natural row-major order. Source and destination memory muxing (input block vs. intermediate buffer) is external and selected by the pass output.

Parameters:
RESET_CYCLES, 3, cycles dct_nreset is held low before each 1-D run (minimum 1)
TIMEOUT_CYCLES, 255, watchdog limit in RUN; used only when DCT_SEQ_WATCHDOG_EN is defined

Ports:
clock  in  1  system clock; all state changes on its rising edge
nreset  in  1  asynchronous active-low reset
start  in  1  one-cycle request to transform one block; sampled only in IDLE
busy  out  1  high in every state except IDLE
block_done  out  1  one-cycle pulse when the 16th run completes
pass  out  1  0 = row pass (source is input block), 1 = column pass (source is intermediate buffer)
line  out  3  current row/column index, 0..7
dct_nreset  out  1  drives the engine's nreset; low = engine held in reset
dct_done  in  1  level from the engine; high once its microcode reaches the end (pc==57); must read low while the engine is in reset
dct_fetch_addr  in  3  engine fetch address
dct_result_addr  in  3  engine result address
dct_result_wren  in  1  engine result write enable
src_raddr  out  6  {line, dct_fetch_addr}; combinational
dst_waddr  out  6  {dct_result_addr, line}; combinational, transposed store
dst_wren  out  1  dct_result_wren AND (state==RUN); combinational
error  out  1  sticky watchdog flag; constant 0 without DCT_SEQ_WATCHDOG_EN

Behaviour:
- Reset (async): state=IDLE, pass=0, line=0, dct_nreset=0, busy=0, block_done=0, error=0, internal counters=0.
- IDLE: dct_nreset=0, which parks the engine. If start=1: pass<=0, line<=0, error<=0, go to HOLD. A start seen in any other state is ignored.
- HOLD: dct_nreset=0 and a counter runs for RESET_CYCLES cycles, then the FSM goes to RUN. dct_nreset goes high on the first RUN cycle.
- RUN: dct_nreset=1. dct_done is ignored on the first RUN cycle (it can still show stale state). From the second cycle on, dct_done=1 moves the FSM to NEXT.
- NEXT, one cycle, dct_nreset=0:
  - If line!=7: line<=line+1, go to HOLD.
  - Else if pass==0: pass<=1, line<=0, go to HOLD.
  - Else: block_done=1, pass<=0, line<=0, go to IDLE.
- Address mapping, valid in all states:
  - Pass 0 writes intermediate[k][row].
  - Pass 1 reads intermediate[col][r] and writes final[k][col], giving row-major output with no extra transpose stage.
  - dst_wren is forced to 0 outside RUN, so stale engine strobes during HOLD or NEXT never write.
- Latency per run = RESET_CYCLES + 1 (first RUN cycle) + T_engine + 1 (NEXT). Block latency = 16 x that, plus 1 cycle for IDLE->HOLD.
- Simultaneous dct_done=1 and the final NEXT: block_done and busy deassert in the same cycle, and start is accepted on the following cycle at the earliest.
- nreset asserted mid-block: immediate return to IDLE. Partial results in memory are undefined; no block_done.
- Widths: the sequencer does not touch data. Sign-extension of the 16-bit intermediate into the engine's fetch port in pass 1 is the external mux's responsibility.

Optional Feature:
DCT_SEQ_WATCHDOG_EN
- Defined: an 8-bit+ counter clears on RUN entry. If it reaches TIMEOUT_CYCLES with no dct_done, then error<=1 (sticky until the next accepted start or reset), state<=IDLE, dct_nreset<=0, and no block_done.
- Not defined: no counter, error tied to 0, and RUN waits indefinitely.

Test Plan:
1. Reset, then idle 10 cycles -> dct_nreset=0, busy=0, block_done=0, dst_wren=0 with dct_result_wren forced 1.
2. Behavioural engine model (dct_done 20 cycles after release), start pulse -> 16 HOLD/RUN pairs; (pass,line) steps (0,0)..(0,7),(1,0)..(1,7); block_done pulses once at cycle 16x(3+1+20+1)+1=401; busy falls the same cycle.
3. Real loeffler_dct_8 with an all-0x10 input block -> output mem[0] equals the 2-D DC term from the golden model; mem[1..63]=0. Intermediate column 0 matches the 1-D reference output.
4. Pass 0, line=5, dct_result_addr=3, dct_result_wren=1 -> dst_waddr=6'o35 (29), dst_wren=1; dct_fetch_addr=6 -> src_raddr=6'o56 (46).
5. start re-asserted mid-block at line 3; then nreset pulsed at pass 1, line 2 -> the start is ignored, no restart; after the reset state=IDLE, dct_nreset=0, no block_done.
6. DCT_SEQ_WATCHDOG_EN defined, TIMEOUT_CYCLES=50, model never raises dct_done -> error=1 and busy=0 after 50 RUN cycles; the next start clears error.
